// File: rtl/clock_text_pkg.sv
// Shared constants and types for the clock text renderer.
// No logic; character codes, slot map, mode/edit encodings, snapshot and stage-1 structs.
// Imported by the mapper and the top.
package clock_text_pkg;

    // Glyph ROM character codes
    localparam logic [6:0]  CODE_DIGIT0     = 7'h30;
    localparam logic [6:0]  CODE_COLON      = 7'h3A;
    localparam logic [6:0]  CODE_A          = 7'h3B;
    localparam logic [6:0]  CODE_T          = 7'h3C;
    localparam logic [10:0] CODE_BLANK_ADDR = 11'h300;

    // Character slots of the "HH:MM:SS M" banner
    localparam logic [3:0] SLOT_HOUR_T = 4'd0;
    localparam logic [3:0] SLOT_HOUR_O = 4'd1;
    localparam logic [3:0] SLOT_COLON0 = 4'd2;
    localparam logic [3:0] SLOT_MIN_T  = 4'd3;
    localparam logic [3:0] SLOT_MIN_O  = 4'd4;
    localparam logic [3:0] SLOT_COLON1 = 4'd5;
    localparam logic [3:0] SLOT_SEC_T  = 4'd6;
    localparam logic [3:0] SLOT_SEC_O  = 4'd7;
    localparam logic [3:0] SLOT_SPACE  = 4'd8;
    localparam logic [3:0] SLOT_MODE   = 4'd9;

    // mode_sel encodings
    localparam logic [1:0] MODE_NONE     = 2'd0;
    localparam logic [1:0] MODE_ALARM    = 2'd1;
    localparam logic [1:0] MODE_TIMER    = 2'd2;
    localparam logic [1:0] MODE_NONE_ALT = 2'd3;

    // edit_field encodings
    localparam logic [1:0] EDIT_NONE = 2'd0;
    localparam logic [1:0] EDIT_HOUR = 2'd1;
    localparam logic [1:0] EDIT_MIN  = 2'd2;
    localparam logic [1:0] EDIT_SEC  = 2'd3;

    // Per-frame snapshot of the displayed state
    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] second;
        logic [1:0] mode;
        logic [1:0] edit;
    } snap_t;

    // Stage-1 pipeline word
    typedef struct packed {
        logic [2:0] col;
        logic       blank;
        logic       highlight;
        logic       video_on;
        logic       hsync;
        logic       vsync;
    } stage1_t;

    function automatic logic digit_ok(input logic [3:0] nib);
        return nib <= 4'd9;
    endfunction

endpackage

// File: rtl/clock_text_renderer_if.sv
// Pixel/time/ROM/video bundle between the sync+timekeeping side and the text renderer.
// No logic; master drives pixel, time and ROM data, slave drives ROM address and video out.
// No backpressure: the pixel stream advances on pix_en only.
interface clock_text_renderer_if;
    logic        pix_en;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [7:0]  hour_bcd;
    logic [7:0]  min_bcd;
    logic [7:0]  sec_bcd;
    logic [1:0]  mode_sel;
    logic        colon_on;
    logic [1:0]  edit_field;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic        hsync_out;
    logic        vsync_out;
    logic        text_on;
    logic [11:0] rgb;

    modport master (
        output pix_en, video_on, hsync_in, vsync_in, pixel_x, pixel_y,
        output hour_bcd, min_bcd, sec_bcd, mode_sel, colon_on, edit_field,
        output rom_data,
        input  rom_addr, hsync_out, vsync_out, text_on, rgb
    );

    modport slave (
        input  pix_en, video_on, hsync_in, vsync_in, pixel_x, pixel_y,
        input  hour_bcd, min_bcd, sec_bcd, mode_sel, colon_on, edit_field,
        input  rom_data,
        output rom_addr, hsync_out, vsync_out, text_on, rgb
    );
endinterface

// File: rtl/clock_char_mapper.sv
// Maps a pixel coordinate plus time snapshot to glyph ROM address, glyph column, blank and highlight.
// Latency: purely combinational.
// Backpressure: none. Ports: pixel_x/y, snap, colon_on in; rom_addr, col, blank, highlight out.
module clock_char_mapper
    import clock_text_pkg::*;
#(
    parameter int unsigned X0         = 160,
    parameter int unsigned Y0         = 208,
    parameter int unsigned SCALE_LOG2 = 2
) (
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  snap_t       snap,
    input  logic        colon_on,
    output logic [10:0] rom_addr,
    output logic [2:0]  col,
    output logic        blank,
    output logic        highlight
);

    localparam logic [9:0] X0_L  = 10'(X0);
    localparam logic [9:0] Y0_L  = 10'(Y0);
    localparam logic [9:0] BOX_W = 10'(80 << SCALE_LOG2);
    localparam logic [9:0] BOX_H = 10'(16 << SCALE_LOG2);

    logic [9:0] dx;
    logic [9:0] dy;
    logic       in_box;
    logic [3:0] slot;
    logic [3:0] row;
    logic [3:0] nib;
    logic       is_digit;
    logic       glyph_blank;
    logic [6:0] code;

    always_comb begin
        dx = pixel_x - X0_L;
        dy = pixel_y - Y0_L;
        // dx/dy wrap when left of or above the box; the explicit compares reject that case
        in_box = (pixel_x >= X0_L) && (pixel_y >= Y0_L) && (dx < BOX_W) && (dy < BOX_H);
        slot = 4'(dx >> (3 + SCALE_LOG2));
        col  = 3'(dx >> SCALE_LOG2);
        row  = 4'(dy >> SCALE_LOG2);

        nib         = 4'd0;
        is_digit    = 1'b0;
        glyph_blank = 1'b0;
        code        = CODE_DIGIT0;

        case (slot)
            SLOT_HOUR_T: begin nib = snap.hour[7:4];   is_digit = 1'b1; end
            SLOT_HOUR_O: begin nib = snap.hour[3:0];   is_digit = 1'b1; end
            SLOT_MIN_T:  begin nib = snap.minute[7:4]; is_digit = 1'b1; end
            SLOT_MIN_O:  begin nib = snap.minute[3:0]; is_digit = 1'b1; end
            SLOT_SEC_T:  begin nib = snap.second[7:4]; is_digit = 1'b1; end
            SLOT_SEC_O:  begin nib = snap.second[3:0]; is_digit = 1'b1; end
            SLOT_COLON0, SLOT_COLON1: begin
                code        = CODE_COLON;
                glyph_blank = !colon_on;
            end
            SLOT_MODE: begin
                case (snap.mode)
                    MODE_ALARM:              code = CODE_A;
                    MODE_TIMER:              code = CODE_T;
                    MODE_NONE, MODE_NONE_ALT: glyph_blank = 1'b1;
                endcase
            end
            SLOT_SPACE: glyph_blank = 1'b1;
            default:    glyph_blank = 1'b1;
        endcase

        if (is_digit) begin
            code        = CODE_DIGIT0 + {3'b000, nib};
            glyph_blank = !digit_ok(nib);
        end

        blank = !in_box || glyph_blank;

        case (snap.edit)
            EDIT_HOUR: highlight = (slot == SLOT_HOUR_T) || (slot == SLOT_HOUR_O);
            EDIT_MIN:  highlight = (slot == SLOT_MIN_T)  || (slot == SLOT_MIN_O);
            EDIT_SEC:  highlight = (slot == SLOT_SEC_T)  || (slot == SLOT_SEC_O);
            EDIT_NONE: highlight = 1'b0;
        endcase

        // Blank pixels park the ROM on a known-mapped address
        rom_addr = blank ? CODE_BLANK_ADDR : {code, row};
    end

endmodule

// File: rtl/clock_text_renderer.sv
// Renders the "HH:MM:SS A/T" banner into a 12-bit RGB pixel stream with delayed syncs.
// Latency: 2 pix_en ticks from pixel_x/y/syncs to rgb/syncs out; rom_addr is combinational.
// Backpressure: none; all pipeline state holds while pix_en=0. Ports: clk, rst_n, bus (slave).
module clock_text_renderer
    import clock_text_pkg::*;
#(
    parameter int unsigned X0         = 160,
    parameter int unsigned Y0         = 208,
    parameter int unsigned SCALE_LOG2 = 2,
    parameter logic [11:0] FG_COLOR   = 12'hFFF,
    parameter logic [11:0] HL_COLOR   = 12'hF80,
    parameter logic [11:0] BG_COLOR   = 12'h000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    clock_text_renderer_if.slave  bus
);

    snap_t       snap_q,  snap_d;
    stage1_t     s1_q,    s1_d;
    logic        tick_d1_q, tick_d1_d;
    logic [7:0]  glyph_hold_q, glyph_hold_d;
    logic [11:0] rgb_q,   rgb_d;
    logic        text_q,  text_d;
    logic        hs_q,    hs_d;
    logic        vs_q,    vs_d;

    logic [2:0]  map_col;
    logic        map_blank;
    logic        map_highlight;
    logic [7:0]  glyph_row;
    logic        lit;

    clock_char_mapper #(
        .X0         (X0),
        .Y0         (Y0),
        .SCALE_LOG2 (SCALE_LOG2)
    ) u_mapper (
        .pixel_x   (bus.pixel_x),
        .pixel_y   (bus.pixel_y),
        .snap      (snap_q),
        .colon_on  (bus.colon_on),
        .rom_addr  (bus.rom_addr),
        .col       (map_col),
        .blank     (map_blank),
        .highlight (map_highlight)
    );

    always_comb begin
        snap_d = snap_q;
        if (bus.pix_en && (bus.pixel_x == 10'd0) && (bus.pixel_y == 10'd0)) begin
            snap_d = '{hour:   bus.hour_bcd,
                       minute: bus.min_bcd,
                       second: bus.sec_bcd,
                       mode:   bus.mode_sel,
                       edit:   bus.edit_field};
        end

        s1_d = s1_q;
        if (bus.pix_en) begin
            s1_d = '{col:       map_col,
                     blank:     map_blank,
                     highlight: map_highlight,
                     video_on:  bus.video_on,
                     hsync:     bus.hsync_in,
                     vsync:     bus.vsync_in};
        end

        // The ROM answers one clk after a tick, but the next tick may be many clks later
        // while the address has already moved on to the next pixel. Catch the row in the
        // clk right after each tick; with back-to-back ticks use it straight from the ROM.
        tick_d1_d    = bus.pix_en;
        glyph_row    = tick_d1_q ? bus.rom_data : glyph_hold_q;
        glyph_hold_d = glyph_row;

        lit = glyph_row[3'd7 - s1_q.col] & !s1_q.blank & s1_q.video_on;

        rgb_d  = rgb_q;
        text_d = text_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        if (bus.pix_en) begin
            text_d = lit;
            rgb_d  = !s1_q.video_on ? 12'h000 :
                     lit            ? (s1_q.highlight ? HL_COLOR : FG_COLOR) :
                                      BG_COLOR;
            hs_d   = s1_q.hsync;
            vs_d   = s1_q.vsync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q       <= '0;
            s1_q         <= '0;
            tick_d1_q    <= 1'b0;
            glyph_hold_q <= 8'h00;
            rgb_q        <= 12'h000;
            text_q       <= 1'b0;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
        end else begin
            snap_q       <= snap_d;
            s1_q         <= s1_d;
            tick_d1_q    <= tick_d1_d;
            glyph_hold_q <= glyph_hold_d;
            rgb_q        <= rgb_d;
            text_q       <= text_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
        end
    end

    assign bus.rgb       = rgb_q;
    assign bus.text_on   = text_q;
    assign bus.hsync_out = hs_q;
    assign bus.vsync_out = vs_q;

endmodule

// File: tb/tb_clock_text_renderer.sv
// Self-checking bench for clock_text_renderer: glyph ROM model, banner reference model,
// directed scenarios plus randomized pixel streams with continuous and sparse pix_en.
module tb_clock_text_renderer;

    localparam int X0 = 160;
    localparam int Y0 = 208;
    localparam int SC = 4;   // magnification factor (1 << SCALE_LOG2)

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    clock_text_renderer_if bus ();

    clock_text_renderer #(
        .X0         (X0),
        .Y0         (Y0),
        .SCALE_LOG2 (2),
        .FG_COLOR   (12'hFFF),
        .HL_COLOR   (12'hF80),
        .BG_COLOR   (12'h000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: what the banner should currently show
    logic [7:0]  m_hour, m_min, m_sec;
    logic [1:0]  m_mode, m_edit;
    logic [11:0] q_rgb[$];
    bit          q_text[$];
    bit          q_hs[$];
    bit          q_vs[$];

    // Glyph ROM contents: rows 2 and 4 are 0x7E (outer columns dark), blank address all-on
    function automatic logic [7:0] glyph(input logic [10:0] a);
        if (a == 11'h300) return 8'hFF;
        if (a[3:0] == 4'd2 || a[3:0] == 4'd4) return 8'h7E;
        return 8'((a * 11'd7) ^ (a >> 2)) ^ 8'hA5;
    endfunction

    always @(posedge clk) bus.rom_data <= glyph(bus.rom_addr);

    // Character code shown in a banner position, -1 when nothing is drawn there
    function automatic int banner_code(input int pos);
        int n;
        case (pos)
            0: n = int'(m_hour[7:4]);
            1: n = int'(m_hour[3:0]);
            3: n = int'(m_min[7:4]);
            4: n = int'(m_min[3:0]);
            6: n = int'(m_sec[7:4]);
            7: n = int'(m_sec[3:0]);
            2, 5: return bus.colon_on ? 'h3A : -1;
            9: return (m_mode == 2'd1) ? 'h3B : (m_mode == 2'd2) ? 'h3C : -1;
            default: return -1;
        endcase
        return (n > 9) ? -1 : 'h30 + n;
    endfunction

    function automatic bit inside_box(input int x, input int y);
        return (x >= X0) && (y >= Y0) && (x - X0 < 80 * SC) && (y - Y0 < 16 * SC);
    endfunction

    function automatic int model_addr(input int x, input int y);
        int c;
        if (!inside_box(x, y)) return 'h300;
        c = banner_code((x - X0) / (8 * SC));
        if (c < 0) return 'h300;
        return c * 16 + ((y - Y0) / SC) % 16;
    endfunction

    task automatic model_pixel(input int x, input int y, input bit von,
                               output logic [11:0] rgb, output bit text);
        int pos, col;
        logic [7:0] g;
        bit hl;
        rgb = 12'h000;
        text = 1'b0;
        if (!von || !inside_box(x, y)) return;
        pos = (x - X0) / (8 * SC);
        if (banner_code(pos) < 0) return;
        col = ((x - X0) / SC) % 8;
        g = glyph(11'(model_addr(x, y)));
        text = g[7 - col];
        hl = (m_edit == 2'd1 && pos <= 1) || (m_edit == 2'd2 && (pos == 3 || pos == 4)) ||
             (m_edit == 2'd3 && (pos == 6 || pos == 7));
        if (text) rgb = hl ? 12'hF80 : 12'hFFF;
    endtask

    task automatic reset_model();
        m_hour = 8'h00; m_min = 8'h00; m_sec = 8'h00; m_mode = 2'd0; m_edit = 2'd0;
        q_rgb.delete(); q_text.delete(); q_hs.delete(); q_vs.delete();
    endtask

    // One pixel tick followed by 'gap' idle clocks; checks address and 2-tick-delayed outputs
    task automatic do_tick(input int x, input int y, input bit hs, input bit vs, input bit von,
                           input int gap, output logic [10:0] addr_seen);
        logic [11:0] er;
        bit et, eh, ev;
        int ea;
        bus.pixel_x = 10'(x);
        bus.pixel_y = 10'(y);
        bus.hsync_in = hs;
        bus.vsync_in = vs;
        bus.video_on = von;
        bus.pix_en = 1'b1;
        #1;
        addr_seen = bus.rom_addr;
        ea = model_addr(x, y);
        total++;
        if (bus.rom_addr !== 11'(ea)) begin
            bad++;
            $display("FAIL rom_addr x=%0d y=%0d got=%h exp=%h", x, y, bus.rom_addr, 11'(ea));
        end
        model_pixel(x, y, von, er, et);
        q_rgb.push_back(er); q_text.push_back(et); q_hs.push_back(hs); q_vs.push_back(vs);
        if (x == 0 && y == 0) begin
            m_hour = bus.hour_bcd; m_min = bus.min_bcd; m_sec = bus.sec_bcd;
            m_mode = bus.mode_sel; m_edit = bus.edit_field;
        end
        @(posedge clk);
        #1;
        bus.pix_en = 1'b0;
        if (q_rgb.size() >= 2) begin
            er = q_rgb.pop_front(); et = q_text.pop_front();
            eh = q_hs.pop_front();  ev = q_vs.pop_front();
        end else begin
            er = 12'h000; et = 1'b0; eh = 1'b0; ev = 1'b0;
        end
        total++;
        if (bus.rgb !== er || bus.text_on !== et) begin
            bad++;
            $display("FAIL pixel rgb/text got=%h/%b exp=%h/%b", bus.rgb, bus.text_on, er, et);
        end
        total++;
        if (bus.hsync_out !== eh || bus.vsync_out !== ev) begin
            bad++;
            $display("FAIL sync hs/vs got=%b/%b exp=%b/%b", bus.hsync_out, bus.vsync_out, eh, ev);
        end
        repeat (gap) begin
            @(posedge clk);
            #1;
            total++;
            if ({bus.rgb, bus.text_on, bus.hsync_out, bus.vsync_out} !== {er, et, eh, ev}) begin
                bad++;
                $display("FAIL hold_between_ticks got=%h/%b/%b/%b exp=%h/%b/%b/%b",
                         bus.rgb, bus.text_on, bus.hsync_out, bus.vsync_out, er, et, eh, ev);
            end
        end
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                            input logic [1:0] mode, input logic [1:0] edit);
        bus.hour_bcd = h; bus.min_bcd = m; bus.sec_bcd = s;
        bus.mode_sel = mode; bus.edit_field = edit;
    endtask

    task automatic test_reset();
        logic [10:0] a;
        bus.pix_en = 1'b0; bus.video_on = 1'b1; bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
        bus.pixel_x = 10'(X0 + 20); bus.pixel_y = 10'(Y0 + 8); bus.colon_on = 1'b1;
        set_time(8'h12, 8'h34, 8'h56, 2'd1, 2'd0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.rgb !== 12'h000 || bus.text_on !== 1'b0) begin
            bad++; $display("FAIL reset_rgb got=%h/%b exp=000/0", bus.rgb, bus.text_on);
        end
        total++;
        if (bus.hsync_out !== 1'b0 || bus.vsync_out !== 1'b0) begin
            bad++; $display("FAIL reset_sync got=%b/%b exp=0/0", bus.hsync_out, bus.vsync_out);
        end
        // Cleared snapshot shows '0' in the hour-tens slot
        a = bus.rom_addr;
        total++;
        if (a !== 11'h302) begin
            bad++; $display("FAIL reset_snapshot_addr got=%h exp=302", a);
        end
        reset_model();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [10:0] a;
        set_time(8'h12, 8'h34, 8'h56, 2'd0, 2'd0);
        bus.colon_on = 1'b1;
        do_tick(0, 0, 0, 0, 0, 0, a);
        do_tick(X0 + 20, Y0 + 8, 1, 0, 1, 0, a);
        total++;
        if (a !== 11'h312) begin bad++; $display("FAIL basic_addr got=%h exp=312", a); end
        do_tick(X0, Y0 + 8, 0, 1, 1, 0, a);
        total++;
        if (bus.text_on !== 1'b1 || bus.rgb !== 12'hFFF) begin
            bad++; $display("FAIL basic_lit got=%b/%h exp=1/fff", bus.text_on, bus.rgb);
        end
        do_tick(X0 + 40, Y0 + 8, 0, 0, 1, 0, a);
        total++;
        if (bus.rgb !== 12'h000) begin bad++; $display("FAIL basic_left_col got=%h exp=000", bus.rgb); end
    endtask

    task automatic test_reset_midline();
        logic [10:0] a;
        do_tick(X0 + 20, Y0 + 8, 1, 1, 1, 0, a);
        do_tick(X0 + 20, Y0 + 8, 1, 1, 1, 0, a);
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.rgb, bus.text_on, bus.hsync_out, bus.vsync_out} !== 15'h0) begin
            bad++;
            $display("FAIL midline_reset got=%h/%b/%b/%b exp=000/0/0/0",
                     bus.rgb, bus.text_on, bus.hsync_out, bus.vsync_out);
        end
        reset_model();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        // snapshot is back at 00:00:00 until the next frame start
        for (int i = 0; i < 4; i++) do_tick(X0 + 4 + 8 * i, Y0 + 8, 1, 1, 1, 0, a);
    endtask

    task automatic test_random(input int gap, input int n);
        logic [10:0] a;
        bit hs;
        hs = 1'b0;
        for (int f = 0; f < 3; f++) begin
            set_time({4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))},
                     ($urandom_range(0, 5) == 0) ? 8'($urandom) :
                         {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))},
                     {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))},
                     2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            do_tick(0, 0, hs, 1, 0, gap, a);
            for (int i = 0; i < n; i++) begin
                if (gap > 0) hs = ~hs; else hs = 1'($urandom);
                bus.colon_on = ($urandom_range(0, 3) != 0);
                do_tick(X0 - 8 + int'($urandom_range(0, 340)), Y0 - 4 + int'($urandom_range(0, 72)),
                        hs, 1'($urandom), ($urandom_range(0, 7) != 0), gap, a);
            end
        end
    endtask

    task automatic test_colon();
        logic [10:0] a;
        set_time(8'h12, 8'h34, 8'h56, 2'd0, 2'd0);
        bus.colon_on = 1'b1;
        do_tick(0, 0, 0, 0, 0, 0, a);
        do_tick(X0 + 2 * 32 + 12, Y0 + 16, 0, 0, 1, 0, a);
        total++;
        if (a !== 11'h3A4) begin bad++; $display("FAIL colon_on_addr got=%h exp=3a4", a); end
        bus.colon_on = 1'b0;
        do_tick(X0 + 2 * 32 + 12, Y0 + 16, 0, 0, 1, 0, a);
        total++;
        if (bus.rgb !== 12'hFFF) begin bad++; $display("FAIL colon_on_rgb got=%h exp=fff", bus.rgb); end
        total++;
        if (a !== 11'h300) begin bad++; $display("FAIL colon_off_addr got=%h exp=300", a); end
        do_tick(X0 + 20, Y0 + 8, 0, 0, 1, 0, a);
        total++;
        if (bus.rgb !== 12'h000) begin bad++; $display("FAIL colon_off_rgb got=%h exp=000", bus.rgb); end
        bus.colon_on = 1'b1;
    endtask

    task automatic test_bad_bcd_edit();
        logic [10:0] a;
        set_time(8'h12, 8'hA5, 8'h56, 2'd0, 2'd3);
        do_tick(0, 0, 0, 0, 0, 0, a);
        do_tick(X0 + 100, Y0 + 8, 0, 0, 1, 0, a);
        total++;
        if (a !== 11'h300) begin bad++; $display("FAIL bad_bcd_addr got=%h exp=300", a); end
        do_tick(X0 + 196, Y0 + 8, 0, 0, 1, 0, a);
        total++;
        if (bus.text_on !== 1'b0) begin bad++; $display("FAIL bad_bcd_text got=%b exp=0", bus.text_on); end
        do_tick(X0 + 228, Y0 + 8, 0, 0, 1, 0, a);
        total++;
        if (bus.rgb !== 12'hF80) begin bad++; $display("FAIL edit_sec_tens got=%h exp=f80", bus.rgb); end
        do_tick(X0 + 20, Y0 + 8, 0, 0, 1, 0, a);
        total++;
        if (bus.rgb !== 12'hF80) begin bad++; $display("FAIL edit_sec_ones got=%h exp=f80", bus.rgb); end
    endtask

    task automatic test_snapshot();
        logic [10:0] a;
        set_time(8'h12, 8'h34, 8'h56, 2'd0, 2'd0);
        do_tick(0, 0, 0, 0, 0, 0, a);
        set_time(8'h07, 8'h34, 8'h56, 2'd1, 2'd0);
        do_tick(X0 + 36, Y0 + 8, 0, 0, 1, 0, a);
        total++;
        if (a !== 11'h322) begin bad++; $display("FAIL snapshot_hold_hour got=%h exp=322", a); end
        do_tick(X0 + 292, Y0 + 8, 0, 0, 1, 0, a);
        total++;
        if (a !== 11'h300) begin bad++; $display("FAIL snapshot_hold_mode got=%h exp=300", a); end
        do_tick(0, 0, 0, 0, 0, 0, a);
        do_tick(X0 + 36, Y0 + 8, 0, 0, 1, 0, a);
        total++;
        if (a !== 11'h372) begin bad++; $display("FAIL snapshot_new_hour got=%h exp=372", a); end
        do_tick(X0 + 292, Y0 + 8, 0, 0, 1, 0, a);
        total++;
        if (a !== 11'h3B2) begin bad++; $display("FAIL snapshot_mode_a got=%h exp=3b2", a); end
        bus.mode_sel = 2'd0;
        do_tick(0, 0, 0, 0, 0, 0, a);
        do_tick(X0 + 292, Y0 + 8, 0, 0, 1, 0, a);
        total++;
        if (a !== 11'h300) begin bad++; $display("FAIL snapshot_mode_none got=%h exp=300", a); end
    endtask

    task automatic test_boundary();
        logic [10:0] a;
        set_time(8'h12, 8'h34, 8'h56, 2'd2, 2'd0);
        do_tick(0, 0, 0, 0, 0, 0, a);
        do_tick(X0 + 319, Y0 + 8, 0, 0, 1, 0, a);
        total++;
        if (a !== 11'h3C2) begin bad++; $display("FAIL bound_last_col got=%h exp=3c2", a); end
        do_tick(X0 + 320, Y0 + 8, 0, 0, 1, 0, a);
        total++;
        if (a !== 11'h300) begin bad++; $display("FAIL bound_right_out got=%h exp=300", a); end
        do_tick(X0 - 1, Y0 + 8, 0, 0, 1, 0, a);
        total++;
        if (a !== 11'h300) begin bad++; $display("FAIL bound_left_wrap got=%h exp=300", a); end
        do_tick(X0 + 4, Y0 + 63, 0, 0, 1, 0, a);
        total++;
        if (a !== 11'h31F) begin bad++; $display("FAIL bound_last_row got=%h exp=31f", a); end
        do_tick(X0 + 4, Y0 + 64, 0, 0, 1, 0, a);
        total++;
        if (a !== 11'h300) begin bad++; $display("FAIL bound_below got=%h exp=300", a); end
        do_tick(X0 + 4, Y0 - 1, 0, 0, 1, 0, a);
        total++;
        if (a !== 11'h300) begin bad++; $display("FAIL bound_above got=%h exp=300", a); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_midline();
        test_colon();
        test_bad_bcd_edit();
        test_snapshot();
        test_boundary();
        test_random(0, 150);
        test_random(3, 60);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
